// File: rtl/port_alloc_rr.sv
// port_alloc_rr: five-port round-robin output allocator.
//
// Each input presents at most one routed flit request. Each output grants at
// most one input per cycle, scanning from a per-output round-robin pointer.
// The grant is combinational. The crossbar select and valid are registered, so
// they configure the switch stage for the following cycle. Per-input wait
// counters flag requesters that have gone unserved for too long.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  per-input request valid
//   req_dir    per-input requested output, SELW bits per input
//   out_en     per-output downstream ready
//   grant      per-input grant (combinational), flit consumed at next edge
//   out_sel    per-output driving input index, all ones when idle (registered)
//   out_valid  per-output flit present (registered)
//   starve     per-input starvation flag (registered)
//   dir_err    sticky flag for a valid request to a nonexistent output
module port_alloc_rr #(
  parameter int unsigned NPORT        = 5,
  parameter int unsigned SELW         = 3,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NPORT-1:0]      req_valid,
  input  logic [NPORT*SELW-1:0] req_dir,
  input  logic [NPORT-1:0]      out_en,
  output logic [NPORT-1:0]      grant,
  output logic [NPORT*SELW-1:0] out_sel,
  output logic [NPORT-1:0]      out_valid,
  output logic [NPORT-1:0]      starve,
  output logic                  dir_err
);

  localparam logic [SELW-1:0] SelNone = '1;
  localparam int unsigned     WcntW   = 4;
  localparam logic [WcntW-1:0] WcntMax = '1;

  logic [SELW-1:0]       dir       [NPORT];
  logic [SELW-1:0]       ptr_q     [NPORT];
  logic [SELW-1:0]       ptr_d     [NPORT];
  logic [SELW-1:0]       win_idx   [NPORT];
  logic [NPORT-1:0]      win_found;
  logic [WcntW-1:0]      wcnt_q    [NPORT];
  logic [WcntW-1:0]      wcnt_d    [NPORT];
  logic [NPORT*SELW-1:0] out_sel_q, out_sel_d;
  logic [NPORT-1:0]      out_valid_q;
  logic [NPORT-1:0]      starve_q, starve_d;
  logic                  dir_err_q, dir_err_d;

  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      dir[i] = req_dir[i*SELW +: SELW];
    end
  end

  // Round-robin arbitration: first candidate at or after ptr, wrapping mod NPORT.
  always_comb begin
    int idx;
    idx = 0;
    for (int o = 0; o < NPORT; o++) begin
      win_found[o] = 1'b0;
      win_idx[o]   = SelNone;
      for (int k = 0; k < NPORT; k++) begin
        idx = int'(ptr_q[o]) + k;
        if (idx >= int'(NPORT)) begin
          idx = idx - int'(NPORT);
        end
        if (!win_found[o] && out_en[o] && req_valid[idx] && (dir[idx] == SELW'(o))) begin
          win_found[o] = 1'b1;
          win_idx[o]   = SELW'(idx);
        end
      end
    end
  end

  // An input requests a single output, so at most one output can name it.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NPORT; i++) begin
      for (int o = 0; o < NPORT; o++) begin
        if (win_found[o] && (win_idx[o] == SELW'(i))) begin
          grant[i] = 1'b1;
        end
      end
    end
    if (rst) begin
      grant = '0;
    end
  end

  always_comb begin
    out_sel_d = '1;
    for (int o = 0; o < NPORT; o++) begin
      ptr_d[o] = ptr_q[o];
      if (win_found[o]) begin
        ptr_d[o] = (32'(win_idx[o]) == NPORT - 1) ? '0 : win_idx[o] + 1'b1;
        out_sel_d[o*SELW +: SELW] = win_idx[o];
      end
    end
  end

  // Invalid-direction requests are never granted, so their counters keep running.
  always_comb begin
    dir_err_d = dir_err_q;
    starve_d  = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (!req_valid[i] || grant[i]) begin
        wcnt_d[i] = '0;
      end else if (wcnt_q[i] == WcntMax) begin
        wcnt_d[i] = wcnt_q[i];
      end else begin
        wcnt_d[i] = wcnt_q[i] + 1'b1;
      end
      starve_d[i] = (32'(wcnt_d[i]) >= STARVE_LIMIT);
      if (req_valid[i] && (32'(dir[i]) >= NPORT)) begin
        dir_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPORT; i++) begin
        ptr_q[i]  <= '0;
        wcnt_q[i] <= '0;
      end
      out_sel_q   <= '1;
      out_valid_q <= '0;
      starve_q    <= '0;
      dir_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        ptr_q[i]  <= ptr_d[i];
        wcnt_q[i] <= wcnt_d[i];
      end
      out_sel_q   <= out_sel_d;
      out_valid_q <= win_found;
      starve_q    <= starve_d;
      dir_err_q   <= dir_err_d;
    end
  end

  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
  assign starve    = starve_q;
  assign dir_err   = dir_err_q;

endmodule

// File: doc/port_alloc_rr.md
# port_alloc_rr

Five-port round-robin output allocator for the router datapath. It takes one routed flit request per input port (north, south, east, west, local) and grants each output port to at most one input per cycle. It also drives the registered crossbar select that configures the combinational switch stage for the following cycle, and tracks per-input wait time so starved requesters are flagged.

## Interface
- `NPORT`, default 5: number of ports. Index 0=N, 1=S, 2=E, 3=W, 4=L.
- `SELW`, default 3: width of a port index. 3'b111 means "none".
- `STARVE_LIMIT`, default 8: count of consecutive ungranted valid cycles that raises `starve[i]`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 5: bit i means input i holds a flit this cycle.
- `req_dir` in 15: bits [3i+2:3i] give the requested output port for input i.
- `out_en` in 5: bit o means output o can accept a flit this cycle (downstream free).
- `grant` out 5: combinational; bit i means input i's flit is consumed at the next rising edge.
- `out_sel` out 15: registered; bits [3o+2:3o] give the input index driving output o, or 3'b111.
- `out_valid` out 5: registered; bit o means output o carries a flit this cycle.
- `starve` out 5: registered; bit i means input i has waited at least `STARVE_LIMIT` cycles.
- `dir_err` out 1: registered, sticky; set when a valid request has `req_dir` ≥ 5.

## Operation
- State: per output o, a priority pointer `ptr[o]` (0..4); per input i, a wait counter `wcnt[i]` (4 bits, saturating at 15); the `out_sel`, `out_valid`, `starve` and `dir_err` registers.
- Candidate set for output o: every input i with `req_valid[i]`, `req_dir[i]==o` and `out_en[o]`.
- Winner for output o: the first candidate found scanning indices `ptr[o]`, `ptr[o]+1`, … mod 5. There is at most one winner per output.
- An input requests exactly one output, so at most one grant per input.
- `grant[i]` is 1 iff input i won its output. `grant` is forced to 0 while `rst` is high.
- Pointer update at each edge, for outputs with a winner w: `ptr[o] <= (w==4) ? 0 : w+1`. Outputs with no winner keep their pointer.
- Crossbar registers at each edge: `out_sel[o] <= winner` or 3'b111 when there is no winner; `out_valid[o] <= (winner exists)`.
- Wait counters:
  - `wcnt[i] <= 0` if `!req_valid[i]` or `grant[i]`.
  - Otherwise `wcnt[i]` increments, saturating at 15.
- Starve flag: `starve[i] <= (next wcnt[i] ≥ STARVE_LIMIT)`. It clears on the edge that grants input i.
- Invalid direction: a request with `req_dir ≥ 5` is never granted and its `wcnt` still counts. `dir_err` sets and stays set until reset.
- Handshake: a requester holds `req_valid`/`req_dir` stable until it sees `grant[i]`=1. At that edge the flit is consumed, and the requester may present a new flit in the next cycle. The allocator does not check request stability.

## Timing
- Grant latency is 0 cycles: `grant` is a combinational function of the current request, `out_en` and `ptr`.
- Crossbar latency is 1 cycle: `out_sel`/`out_valid` reflect the grants of the previous cycle.
- Sustained throughput is one flit per output per cycle. Back-to-back grants to the same input on consecutive cycles are allowed.
- Reset values (edge with `rst`=1):
  - `ptr` = 0, `wcnt` = 0.
  - `out_sel` = all 3'b111, `out_valid` = 0.
  - `starve` = 0, `dir_err` = 0.
- While `rst`=1, `grant`=0. Reset asserted mid-operation drops every in-flight grant, and requests present during reset are not consumed.
- Fairness: with `out_en[o]` held at 1, any valid request for o is granted within 5 cycles. `starve` can therefore only assert when `out_en` is low or `req_dir` is invalid.
- Simultaneous events:
  - A `wcnt` that reaches `STARVE_LIMIT` on the same edge as a grant is cleared; the grant wins.
  - An output with `out_en` low keeps its `ptr`.

## Test plan
- Reset then a single request: N requests E (`req_dir[2:0]`=2), `out_en`=5'h1F → `grant`=5'b00001 in the same cycle. Next cycle `out_sel[8:6]`=0, `out_valid`=5'b00100, `ptr[2]`=1.
- Contention: N and S both request E and hold their requests, with `ptr[2]`=0 → cycle 1 grants N, cycle 2 grants S. `out_sel[8:6]` shows 0 then 1, and `ptr[2]` ends at 2.
- Full permutation: N→S, S→N, E→W, W→L, L→E all valid → `grant`=5'h1F, and next cycle `out_valid`=5'h1F with `out_sel` = {L:3, W:2, E:4, S:0, N:1}.
- Backpressure starvation: W requests L with `out_en[4]`=0 for 8 cycles → `starve[3]`=1 after the 8th edge. Raising `out_en[4]` gives `grant[3]`=1, and `starve[3]`=0 at the next edge.
- Invalid direction: L valid with `req_dir`=3'd6 → `grant[4]` stays 0, `dir_err`=1 next cycle and stays 1 after the request drops; only `rst` clears it.
- Reset mid-stream: a five-input load running, then `rst` held for 1 cycle → `grant`=0 during reset. After the edge, `out_valid`=0, `out_sel`=15'h7FFF, and all pointers return to 0, checked by repeating the contention test.
